muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have these ports, in this order:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  E-stage instruction is DIV/DIVU; held high while `stall_o` is high.
- `req_signed`  in  1  1 = DIV, 0 = DIVU.
- `req_a`  in  32  dividend.
- `req_b`  in  32  divisor.
- `cancel`  in  1  exception/flush; kills the in-flight division.
- `div_start`  out  1  start to divider; held high until `div_ready`.
- `div_signed`  out  1  signedness to divider.
- `div_a`  out  32  latched dividend to divider.
- `div_b`  out  32  latched divisor to divider.
- `div_annul`  out  1  one-cycle abort pulse to divider.
- `div_result`  in  64  {remainder, quotient} from divider.
- `div_ready`  in  1  divider result valid.
- `stall_o`  out  1  pipeline stall request.
- `hilo_we`  out  1  one-cycle HI/LO write enable.
- `hilo_wdata`  out  64  {HI, LO} write data.
- `err_timeout`  out  1  one-cycle pulse on watchdog abort.

Function
REQ-002 The FSM SHALL have states IDLE, BUSY and DONE, with state and all outputs except `stall_o` registered.
REQ-003 In IDLE with `req_valid`=1 and `cancel`=0, the block SHALL latch `req_a`/`req_b`/`req_signed` into `div_a`/`div_b`/`div_signed`, set `div_start`=1 and enter BUSY on the next edge.
REQ-004 `stall_o` SHALL be combinational: (IDLE & `req_valid` & ~`cancel`) | BUSY; it SHALL be 0 in DONE.
REQ-005 In BUSY, `div_a`, `div_b` and `div_signed` SHALL stay constant regardless of `req_*` changes.
REQ-006 In BUSY with `div_ready`=1 and `cancel`=0, the block SHALL capture `div_result` into `hilo_wdata`, clear `div_start` and enter DONE.
REQ-007 In DONE, the block SHALL assert `hilo_we`=1 for exactly one cycle, then return to IDLE.
REQ-008 `req_valid` SHALL be ignored in DONE, so the same instruction never restarts.
REQ-009 Latency SHALL be one cycle after `div_ready`, plus one cycle for `hilo_we` (request->IDLE->BUSY ... ready->DONE).
REQ-010 `cancel` in BUSY SHALL clear `div_start`, pulse `div_annul` for one cycle and return to IDLE without writing HI/LO; this applies even when `div_ready`=1 in the same cycle.
REQ-011 `cancel` in DONE SHALL suppress `hilo_we`; the FSM still returns to IDLE.
REQ-012 A 6-bit watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-013 When the watchdog reaches 63 without `div_ready`, the block SHALL pulse `div_annul` and `err_timeout`, clear `div_start` and return to IDLE with no HI/LO write.
REQ-014 Back-to-back divisions SHALL be accepted, with the second request taken in IDLE on the cycle after DONE.
REQ-015 `hilo_wdata` SHALL hold its last value when `hilo_we`=0.

Reset
REQ-016 On `rst`=1 at a clock edge, the block SHALL enter IDLE and clear `div_start`, `div_signed`, `div_annul`, `hilo_we` and `err_timeout` to 0, `div_a`, `div_b` and `hilo_wdata` to 0, and the watchdog to 0.
REQ-017 `stall_o` SHALL be 0 while `rst`=1.
REQ-018 When `rst` is asserted mid-BUSY, the block SHALL abandon the operation without pulsing `div_annul`; the divider shares `rst`.

Configuration
REQ-019 With macro `DIV_ZERO_BYPASS_EN` defined, an IDLE request with `req_b`==0 SHALL skip BUSY and go straight to DONE.
- `div_start` stays 0.
- `hilo_wdata` = {`req_a`, 32'hFFFF_FFFF}.
- `stall_o` is high for exactly one cycle.
REQ-020 Without `DIV_ZERO_BYPASS_EN`, divide-by-zero SHALL be sent to the divider like any other operand.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DIVU 100/7, divider ready after 33 cycles -> `hilo_we` one cycle after ready; `hilo_wdata`=0x00000002_0000000E.
- DIV -7/2 -> `hilo_wdata`=0xFFFFFFFF_FFFFFFFD; `div_a` stable while `req_a` is toggled during BUSY.
- `cancel` at BUSY cycle 10 -> `div_annul` pulse, `div_start`=0, no `hilo_we`, IDLE next cycle.
- `div_ready` and `cancel` together -> no `hilo_we`.
- Two consecutive DIVU ops (10/3, 9/4) -> two `hilo_we` pulses, {1,3} then {1,2}.
- `div_ready` never asserted -> `err_timeout` after 63 BUSY cycles.
- `rst` mid-BUSY -> all outputs 0 next cycle.
- With `DIV_ZERO_BYPASS_EN`, DIVU 5/0 -> `hilo_wdata`=0x00000005_FFFFFFFF and `div_start` never high.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Sequencing controller between the pipeline E stage and a multi-cycle divider.
// Optional macro DIV_ZERO_BYPASS_EN: a divide-by-zero skips the divider and completes directly.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        err_timeout
);

  // state | meaning
  // IDLE  | waiting for a DIV/DIVU in E
  // BUSY  | divider running, operands frozen, watchdog counting
  // DONE  | result captured; the HI/LO write fires on the way out
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] WDOG_LAST = 6'd62;

  state_t      state_q, state_d;
  logic        start_d, signed_d, annul_d, we_d, tmo_d;
  logic [31:0] a_d, b_d;
  logic [63:0] wdata_d;
  logic [5:0]  wdog_q, wdog_d;
  logic        zero_bypass;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_bypass = (req_b == 32'd0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign stall_o = ~rst &
                   (((state_q == S_IDLE) & req_valid & ~cancel) | (state_q == S_BUSY));

  always_comb begin
    state_d  = state_q;
    start_d  = div_start;
    signed_d = div_signed;
    a_d      = div_a;
    b_d      = div_b;
    wdata_d  = hilo_wdata;
    wdog_d   = wdog_q;
    annul_d  = 1'b0;
    we_d     = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !cancel) begin
          if (zero_bypass) begin
            wdata_d = {req_a, 32'hFFFF_FFFF};
            state_d = S_DONE;
          end else begin
            a_d      = req_a;
            b_d      = req_b;
            signed_d = req_signed;
            start_d  = 1'b1;
            wdog_d   = 6'd0;
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        wdog_d = wdog_q + 6'd1;
        if (cancel) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = S_IDLE;
        end else if (div_ready) begin
          wdata_d = div_result;
          start_d = 1'b0;
          state_d = S_DONE;
        end else if (wdog_q == WDOG_LAST) begin
          // 63rd BUSY cycle with no result: give up on the divider
          start_d = 1'b0;
          annul_d = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        // write enable registered off the DONE cycle so a flush seen here can still kill it
        we_d    = ~cancel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      div_annul   <= 1'b0;
      hilo_we     <= 1'b0;
      hilo_wdata  <= 64'd0;
      err_timeout <= 1'b0;
      wdog_q      <= 6'd0;
    end else begin
      state_q     <= state_d;
      div_start   <= start_d;
      div_signed  <= signed_d;
      div_a       <= a_d;
      div_b       <= b_d;
      div_annul   <= annul_d;
      hilo_we     <= we_d;
      hilo_wdata  <= wdata_d;
      err_timeout <= tmo_d;
      wdog_q      <= wdog_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand sequences and a randomized run.
// The bench plays the divider; expectations come from plain arithmetic and outcome rules.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_signed, cancel, div_ready;
  logic [31:0] req_a, req_b;
  logic [63:0] div_result;
  logic        div_start, div_signed, div_annul, stall_o, hilo_we, err_timeout;
  logic [31:0] div_a, div_b;
  logic [63:0] hilo_wdata;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] last_wdata = 64'd0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .cancel(cancel),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
    .stall_o(stall_o), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          lat;       // BUSY cycle in which div_ready rises; 0 = never
    int          cxl;       // BUSY cycle in which cancel rises; 0 = never
    bit          cxl_done;  // flush during DONE
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // One division from IDLE; outcome follows cancel > ready > watchdog(63 BUSY cycles).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat, input int cxl, input bit cxl_done,
                        input logic [63:0] exp, input bit launched,
                        input bit nxt, input logic [31:0] na, input logic [31:0] nb,
                        input logic ns);
    int e;
    bit tmo, rdy, bad_stall, bad_hold;
    e = 63; tmo = 1'b1; rdy = 1'b0;
    if (lat > 0 && lat <= 63) begin e = lat; tmo = 1'b0; rdy = 1'b1; end
    if (cxl > 0 && cxl <= e) begin e = cxl; tmo = 1'b0; rdy = 1'b0; end
    if (!launched) begin
      req_valid = 1'b1; req_a = a; req_b = b; req_signed = s;
    end
    #1 chk("stall_req", 64'(stall_o), 64'(1));
    step();
    chk("start", 64'(div_start), 64'(1));
    chk("div_a", 64'(div_a), 64'(a));
    chk("div_b", 64'(div_b), 64'(b));
    chk("div_signed", 64'(div_signed), 64'(s));
    chk("we_busy", 64'(hilo_we), 64'(0));
    bad_stall = 1'b0; bad_hold = 1'b0;
    for (int k = 1; k <= e; k++) begin
      div_ready  = (k == lat);
      div_result = (k == lat) ? exp : {$urandom, $urandom};
      cancel     = (k == cxl);
      req_a      = $urandom;
      req_b      = $urandom;
      req_signed = ~s;
      #1 if (stall_o !== 1'b1) bad_stall = 1'b1;
      step();
      if (k < e && (div_a !== a || div_b !== b || div_signed !== s ||
                    div_start !== 1'b1 || div_annul !== 1'b0 || err_timeout !== 1'b0))
        bad_hold = 1'b1;
    end
    div_ready = 1'b0; cancel = 1'b0;
    req_a = a; req_b = b; req_signed = s;
    chk("busy_stall", 64'(bad_stall), 64'(0));
    chk("busy_hold", 64'(bad_hold), 64'(0));
    chk("end_div_a", 64'(div_a), 64'(a));
    if (rdy) begin
      last_wdata = exp;
      chk("done_start", 64'(div_start), 64'(0));
      chk("done_wdata", hilo_wdata, exp);
      chk("done_we", 64'(hilo_we), 64'(0));
      chk("done_annul", 64'(div_annul), 64'(0));
      cancel = cxl_done;
      #1 chk("done_stall", 64'(stall_o), 64'(0));
      step();
      cancel = 1'b0;
      if (nxt) begin
        req_a = na; req_b = nb; req_signed = ns;
      end else begin
        req_valid = 1'b0;
      end
      chk("hilo_we", 64'(hilo_we), 64'(!cxl_done));
      chk("no_restart", 64'(div_start), 64'(0));
      if (!nxt) begin
        step();
        chk("we_pulse", 64'(hilo_we), 64'(0));
        chk("wdata_hold", hilo_wdata, exp);
      end
    end else begin
      chk("abort_annul", 64'(div_annul), 64'(1));
      chk("abort_tmo", 64'(err_timeout), 64'(tmo));
      chk("abort_start", 64'(div_start), 64'(0));
      chk("abort_we", 64'(hilo_we), 64'(0));
      chk("abort_wdata", hilo_wdata, last_wdata);
      req_valid = 1'b0;
      #1 chk("abort_stall", 64'(stall_o), 64'(0));
      step();
      chk("annul_pulse", 64'(div_annul), 64'(0));
      chk("tmo_pulse", 64'(err_timeout), 64'(0));
      chk("abort_no_we", 64'(hilo_we), 64'(0));
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd100,        32'd7,          1'b0, 33, 0,  1'b0, 64'h00000002_0000000E};
    vecs[1] = '{32'd7,          32'd2,          1'b0, 63, 0,  1'b0, 64'h00000001_00000003};
    vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 12, 0,  1'b0, 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{32'd1000,       32'd10,         1'b0, 20, 10, 1'b0, 64'h00000000_00000064};
    vecs[4] = '{32'd50,         32'd5,          1'b0, 8,  8,  1'b0, 64'h00000000_0000000A};
    vecs[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 5,  0,  1'b1, 64'h00000001_FFFFFFFD};
    vecs[6] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1,  0,  1'b0, 64'h00000000_FFFFFFFF};

    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
    cancel = 1'b0; div_ready = 1'b0; div_result = '0;
    step(); step();
    chk("rst_start", 64'(div_start), 64'(0));
    chk("rst_signed", 64'(div_signed), 64'(0));
    chk("rst_div_a", 64'(div_a), 64'(0));
    chk("rst_div_b", 64'(div_b), 64'(0));
    chk("rst_annul", 64'(div_annul), 64'(0));
    chk("rst_we", 64'(hilo_we), 64'(0));
    chk("rst_wdata", hilo_wdata, 64'(0));
    chk("rst_tmo", 64'(err_timeout), 64'(0));
    req_valid = 1'b1; req_a = 32'd9; req_b = 32'd3;
    #1 chk("rst_stall", 64'(stall_o), 64'(0));
    step();
    chk("rst_no_start", 64'(div_start), 64'(0));
    rst = 1'b0; req_valid = 1'b0;
    step();

    // flush in IDLE blocks the request
    req_valid = 1'b1; cancel = 1'b1; req_a = 32'd4; req_b = 32'd2;
    #1 chk("idle_cxl_stall", 64'(stall_o), 64'(0));
    step();
    chk("idle_cxl_start", 64'(div_start), 64'(0));
    req_valid = 1'b0; cancel = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lat, vecs[i].cxl, vecs[i].cxl_done,
             vecs[i].exp, 1'b0, 1'b0, '0, '0, 1'b0);

    // back-to-back DIVU 10/3 then 9/4
    run_op(32'd10, 32'd3, 1'b0, 6, 0, 1'b0, 64'h00000001_00000003, 1'b0,
           1'b1, 32'd9, 32'd4, 1'b0);
    run_op(32'd9, 32'd4, 1'b0, 4, 0, 1'b0, 64'h00000001_00000002, 1'b1,
           1'b0, '0, '0, 1'b0);

    // divider never answers
    run_op(32'd123, 32'd4, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b0, '0, '0, 1'b0);

    // reset while BUSY
    req_valid = 1'b1; req_a = 32'h0000_1234; req_b = 32'd5; req_signed = 1'b1;
    step();
    chk("mid_start", 64'(div_start), 64'(1));
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1; req_valid = 1'b0;
    step();
    chk("mrst_start", 64'(div_start), 64'(0));
    chk("mrst_signed", 64'(div_signed), 64'(0));
    chk("mrst_div_a", 64'(div_a), 64'(0));
    chk("mrst_div_b", 64'(div_b), 64'(0));
    chk("mrst_annul", 64'(div_annul), 64'(0));
    chk("mrst_we", 64'(hilo_we), 64'(0));
    chk("mrst_wdata", hilo_wdata, 64'(0));
    chk("mrst_tmo", 64'(err_timeout), 64'(0));
    chk("mrst_stall", 64'(stall_o), 64'(0));
    last_wdata = 64'd0;
    rst = 1'b0;
    step();
    chk("post_rst_annul", 64'(div_annul), 64'(0));

    // divide by zero
`ifdef DIV_ZERO_BYPASS_EN
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd0; req_signed = 1'b0;
    #1 chk("bz_stall", 64'(stall_o), 64'(1));
    step();
    chk("bz_start", 64'(div_start), 64'(0));
    chk("bz_wdata", hilo_wdata, 64'h00000005_FFFFFFFF);
    #1 chk("bz_done_stall", 64'(stall_o), 64'(0));
    step();
    req_valid = 1'b0;
    chk("bz_we", 64'(hilo_we), 64'(1));
    chk("bz_start2", 64'(div_start), 64'(0));
    step();
    chk("bz_we_pulse", 64'(hilo_we), 64'(0));
    last_wdata = 64'h00000005_FFFFFFFF;
`else
    run_op(32'd5, 32'd0, 1'b0, 4, 0, 1'b0, ref_div(32'd5, 32'd0, 1'b0), 1'b0,
           1'b0, '0, '0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      int          rl, rc;
      bit          rd;
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      if ($urandom_range(0, 2) == 0) rb = {28'd0, rb[3:0]} | 32'd1;
      rs = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 0;
      rd = ($urandom_range(0, 7) == 0);
      run_op(ra, rb, rs, rl, rc, rd, ref_div(ra, rb, rs), 1'b0, 1'b0, '0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
